// File: rtl/keypad_bcd_encoder.sv
// keypad_bcd_encoder: debounces ten active-high digit keys into a 4-bit BCD
// code with a valid/ready handshake. One code per press, no auto-repeat, and
// multi-key chords are rejected and flagged while the encoder is armed.
module keypad_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key,
    input  logic       ready,
    output logic [3:0] digit,
    output logic       valid,
    output logic       multi
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_REARM  = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_n;
    logic [9:0]       key_m, key_s;
    logic [9:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       digit_n, cand_idx;
    logic             valid_n, multi_n;
    logic             is_none, is_single, is_chord;

    // Two-flop synchronizer: raw keys are asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m <= '0;
            key_s <= '0;
        end else begin
            key_m <= key;
            key_s <= key_m;
        end
    end

    // Classify the synchronized sample: a single key clears to zero when its
    // lowest set bit is removed
    always_comb begin
        is_none   = (key_s == 10'd0);
        is_single = !is_none && ((key_s & (key_s - 10'd1)) == 10'd0);
        is_chord  = !is_none && !is_single;
    end

    // Index of the captured key; cand is one-hot whenever it is used
    always_comb begin
        cand_idx = 4'd0;
        for (int i = 0; i < 10; i++)
            if (cand[i]) cand_idx = 4'(i);
    end

    // Next-state and output logic
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        digit_n = digit;
        valid_n = valid;
        multi_n = ((state == IDLE) || (state == DEBOUNCE)) && is_chord;
        case (state)
            IDLE: begin
                if (is_single) begin
                    cand_n  = key_s;
                    cnt_n   = CNT_W'(1);
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (key_s != cand) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_ACCEPT) begin
                    digit_n = cand_idx;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                // accepted press survives key release until consumed
                if (valid && ready) begin
                    valid_n = 1'b0;
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!is_none) begin
                    cnt_n = '0;
                end else if (cnt == CNT_REARM) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            digit <= 4'd0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
            digit <= digit_n;
            valid <= valid_n;
            multi <= multi_n;
        end
    end

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: run-length reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_keypad_bcd_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] key = '0;
    logic       ready = 1'b0;
    logic [3:0] digit;
    logic       valid, multi;

    int total = 0;
    int bad = 0;
    int vld_cycles = 0;
    bit multi_seen = 0;

    keypad_bcd_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .key(key), .ready(ready),
        .digit(digit), .valid(valid), .multi(multi)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int idx(logic [9:0] v);
        int r = 0;
        for (int i = 0; i < 10; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference model: a press is accepted on the (D+1)-th consecutive sample
    // of the same single key while armed; after consumption, D consecutive
    // all-zero samples re-arm. Chords while armed raise multi one edge later.
    logic [9:0] m_k1, m_ks, m_prev, s;
    int         m_run, m_zrun;
    bit         m_valid, m_rel, m_multi, armed, nm;
    logic [3:0] m_digit;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k1 = '0; m_ks = '0; m_prev = '0; m_run = 0; m_zrun = 0;
            m_valid = 0; m_rel = 0; m_multi = 0; m_digit = 4'd0;
        end else begin
            s     = m_ks;
            armed = !m_valid && !m_rel;
            nm    = armed && ($countones(s) >= 2);
            if (m_valid) begin
                if (ready) begin
                    m_valid = 0; m_rel = 1; m_zrun = 0;
                end
            end else if (m_rel) begin
                if (s == 10'd0) begin
                    m_zrun++;
                    if (m_zrun == D) begin m_rel = 0; m_run = 0; end
                end else begin
                    m_zrun = 0;
                end
            end else begin
                if (m_run > 0 && s == m_prev) m_run++;
                else if (m_run > 0) m_run = 0;
                else if ($countones(s) == 1) begin m_run = 1; m_prev = s; end
                if (m_run == D + 1) begin
                    m_valid = 1; m_digit = 4'(idx(s)); m_run = 0;
                end
            end
            m_multi = nm;
            m_ks = m_k1;
            m_k1 = key;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("model_valid", int'(valid), int'(m_valid));
            check("model_digit", int'(digit), int'(m_digit));
            check("model_multi", int'(multi), int'(m_multi));
            if (valid) vld_cycles++;
            if (multi) multi_seen = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid_timeout", int'(valid), 1);
    endtask

    // Consume the pending code, then release and let the encoder re-arm
    task automatic consume_release();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        key = '0;
        tick(D + 4);
    endtask

    int kind, len, a, b;
    logic [9:0] pat;

    initial begin
        // reset values
        #1 rst = 1'b1;
        #1;
        check("rst_valid", int'(valid), 0);
        check("rst_digit", int'(digit), 0);
        check("rst_multi", int'(multi), 0);
        tick(2);
        rst = 1'b0;

        // clean press of key 3: valid after exactly D+3 edges
        tick(1);
        key = 10'b0000001000;
        tick(D + 2);
        check("press_early", int'(valid), 0);
        tick(1);
        check("press_valid", int'(valid), 1);
        check("press_digit", int'(digit), 3);
        tick(20);
        check("press_hold", int'(valid), 1);
        ready = 1'b1;
        tick(1);
        check("press_handshake", int'(valid), 0);
        check("press_digit_kept", int'(digit), 3);
        ready = 1'b0;
        key = '0;
        tick(D + 4);

        // no repeat while held, second press after a 4-cycle release
        vld_cycles = 0;
        ready = 1'b1;
        key = 10'd1 << 5;
        tick(100);
        check("norepeat_pulses", vld_cycles, 1);
        check("norepeat_digit", int'(digit), 5);
        key = '0;
        tick(4);
        key = 10'd1 << 5;
        tick(20);
        check("repress_pulses", vld_cycles, 2);
        ready = 1'b0;
        key = '0;
        tick(D + 4);

        // bounce on key 9: 1,0 then steady ones
        key = 10'd1 << 9;
        tick(1);
        key = '0;
        tick(1);
        key = 10'd1 << 9;
        tick(D + 2);
        check("bounce_early", int'(valid), 0);
        tick(1);
        check("bounce_valid", int'(valid), 1);
        check("bounce_digit", int'(digit), 9);
        consume_release();

        // chord 2+6, then release 6
        key = (10'd1 << 2) | (10'd1 << 6);
        tick(2);
        check("chord_multi_early", int'(multi), 0);
        tick(1);
        check("chord_multi", int'(multi), 1);
        tick(10);
        check("chord_multi_level", int'(multi), 1);
        check("chord_no_valid", int'(valid), 0);
        key = 10'd1 << 2;
        tick(D + 3);
        check("chord_multi_clear", int'(multi), 0);
        check("chord_valid", int'(valid), 1);
        check("chord_digit", int'(digit), 2);
        consume_release();

        // sweep keys 0..9
        multi_seen = 0;
        vld_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            key = 10'd1 << k;
            wait_valid(40);
            check("sweep_digit", int'(digit), k);
            consume_release();
        end
        check("sweep_pulses", vld_cycles, 10);
        check("sweep_multi", int'(multi_seen), 0);

        // asynchronous reset mid-HOLD with digit 7, key kept held
        key = 10'd1 << 7;
        tick(D + 3);
        check("hold7_valid", int'(valid), 1);
        check("hold7_digit", int'(digit), 7);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", int'(valid), 0);
        check("midrst_digit", int'(digit), 0);
        check("midrst_multi", int'(multi), 0);
        tick(1);
        rst = 1'b0;
        tick(D + 2);
        check("postrst_early", int'(valid), 0);
        tick(1);
        check("postrst_valid", int'(valid), 1);
        check("postrst_digit", int'(digit), 7);
        consume_release();

        // randomized segments checked by the model
        for (int seg = 0; seg < 400; seg++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 14);
            a    = $urandom_range(0, 9);
            b    = $urandom_range(0, 9);
            pat  = 10'd1 << a;
            if (kind == 6) pat = pat | (10'd1 << b);
            if (kind == 7) pat = '0;
            for (int c = 0; c < len; c++) begin
                key   = (kind == 8 && $urandom_range(0, 2) == 0) ? 10'd0 : pat;
                ready = ($urandom_range(0, 3) != 0);
                tick(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
